// File: rtl/tpg_pkg.sv
// -----------------------------------------------------------------------------
// tpg_pkg -- shared definitions for the VGA test pattern generator.
//   * pattern index constants PAT_BLACK..PAT_BOX
//   * dir_e : bouncing-box axis direction (DIR_INC = right/down, DIR_DEC = left/up)
//   * bar_color() : colour-bar lookup, returns {red, green, blue} one bit each
// -----------------------------------------------------------------------------
package tpg_pkg;

   localparam logic [3:0] PAT_BLACK  = 4'd0;
   localparam logic [3:0] PAT_RED    = 4'd1;
   localparam logic [3:0] PAT_GREEN  = 4'd2;
   localparam logic [3:0] PAT_BLUE   = 4'd3;
   localparam logic [3:0] PAT_BARS   = 4'd4;
   localparam logic [3:0] PAT_BORDER = 4'd5;
   localparam logic [3:0] PAT_RAMP   = 4'd6;
   localparam logic [3:0] PAT_BOX    = 4'd7;

   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } dir_e;

   // Bar b: red = ~b[1], green = ~b[2], blue = ~b[0]; bar 0 is white, bar 7 black.
   function automatic logic [2:0] bar_color(input logic [2:0] bar);
      return {~bar[1], ~bar[2], ~bar[0]};
   endfunction

endpackage

// File: rtl/tpg_bounce_box.sv
// -----------------------------------------------------------------------------
// tpg_bounce_box -- per-frame position state of the bouncing box.
// The box top-left corner moves STEP pixels per strobe on each axis and
// reflects at 0 and at EXTENT-SIZE.
// Ports:
//   i_clk     pixel clock
//   i_rst_n   synchronous active-low reset (position 0,0, moving right/down)
//   i_strobe  frame strobe; position advances only on this pulse
//   o_x, o_y  registered box corner position
// -----------------------------------------------------------------------------
module tpg_bounce_box
   import tpg_pkg::*;
#(
   parameter int POS_WIDTH = 10,
   parameter int H_EXTENT  = 640,
   parameter int V_EXTENT  = 480,
   parameter int SIZE      = 32,
   parameter int STEP      = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_strobe,
   output logic [POS_WIDTH-1:0] o_x,
   output logic [POS_WIDTH-1:0] o_y
);

   typedef struct packed {
      logic [POS_WIDTH-1:0] pos;
      dir_e                 dir;
   } axis_t;

   axis_t x_q, x_d, y_q, y_d;

   // One axis step; arithmetic in int so pos+STEP cannot wrap before the compare.
   function automatic axis_t axis_next(input axis_t cur, input int extent);
      axis_t nxt;
      int    lim;
      int    p;
      nxt = cur;
      lim = extent - SIZE;
      p   = int'(cur.pos);
      if (cur.dir == DIR_INC) begin
         if (p + STEP >= lim) begin
            nxt.pos = POS_WIDTH'(lim);
            nxt.dir = DIR_DEC;
         end else begin
            nxt.pos = POS_WIDTH'(p + STEP);
         end
      end else begin
         if (p <= STEP) begin
            nxt.pos = '0;
            nxt.dir = DIR_INC;
         end else begin
            nxt.pos = POS_WIDTH'(p - STEP);
         end
      end
      return nxt;
   endfunction

   // Next position: hold between strobes, step both axes on a strobe.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (i_strobe) begin
         x_d = axis_next(x_q, H_EXTENT);
         y_d = axis_next(y_q, V_EXTENT);
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // Position/direction registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         x_q <= '{pos: '0, dir: DIR_INC};
         y_q <= '{pos: '0, dir: DIR_INC};
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign o_x = x_q.pos;
   assign o_y = y_q.pos;

endmodule

// File: rtl/tpg_engine.sv
// -----------------------------------------------------------------------------
// tpg_engine -- parametrised VGA test pattern generator.
// Pattern selection is latched on the frame strobe (manual or auto-cycle),
// colour is produced through a two-stage registered pipeline (latency 2 from
// i_hpos/i_vpos/i_visible), and outputs are forced to 0 outside the visible area.
// Optional build macro: TPG_CROSSHAIR_EN adds a one-pixel white crosshair at
// the screen centre over every pattern except black.
// Ports:
//   i_clk, i_rst_n          pixel clock, synchronous active-low reset
//   i_pattern, i_auto_en    requested pattern, auto-cycle enable
//   i_hpos, i_vpos          current pixel position
//   i_visible               pixel is in the visible area
//   i_frame_strobe          one-cycle pulse at frame start
//   o_red/grn/blu_video     colour channels (COLOR_WIDTH each)
//   o_active_pattern        pattern currently displayed
// -----------------------------------------------------------------------------
module tpg_engine
   import tpg_pkg::*;
#(
   parameter int COLOR_WIDTH  = 3,
   parameter int POS_WIDTH    = 10,
   parameter int H_VISIBLE    = 640,
   parameter int V_VISIBLE    = 480,
   parameter int NUM_PATTERNS = 8,
   parameter int AUTO_FRAMES  = 120,
   parameter int BOX_SIZE     = 32,
   parameter int BOX_STEP     = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [3:0]             i_pattern,
   input  logic                   i_auto_en,
   input  logic [POS_WIDTH-1:0]   i_hpos,
   input  logic [POS_WIDTH-1:0]   i_vpos,
   input  logic                   i_visible,
   input  logic                   i_frame_strobe,
   output logic [COLOR_WIDTH-1:0] o_red_video,
   output logic [COLOR_WIDTH-1:0] o_grn_video,
   output logic [COLOR_WIDTH-1:0] o_blu_video,
   output logic [3:0]             o_active_pattern
);

   localparam int                     BAR_W     = H_VISIBLE / 8;
   localparam int                     BAND_W    = H_VISIBLE >> COLOR_WIDTH;
   localparam int                     NUM_BANDS = 1 << COLOR_WIDTH;
   localparam logic [4:0]             NUM_PAT_L = 5'(NUM_PATTERNS);
   localparam logic [3:0]             LAST_PAT  = 4'(NUM_PATTERNS - 1);
   localparam logic [7:0]             CNT_LAST  = 8'(AUTO_FRAMES - 1);
   localparam logic [COLOR_WIDTH-1:0] ONES      = {COLOR_WIDTH{1'b1}};

   // ---------------------------------------------------------------- pattern latch
   logic [3:0] pat_q, pat_d;
   logic [7:0] cnt_q, cnt_d;

   // Pattern/auto-counter next state; pattern only ever changes on a strobe.
   always_comb begin
      pat_d = pat_q;
      cnt_d = cnt_q;
      if (!i_auto_en) begin
         cnt_d = 8'd0;
         if (i_frame_strobe) begin
            pat_d = ({1'b0, i_pattern} < NUM_PAT_L) ? i_pattern : PAT_BLACK;
         end else begin
            pat_d = pat_q;
         end
      end else if (i_frame_strobe) begin
         if (cnt_q >= CNT_LAST) begin
            cnt_d = 8'd0;
            // Auto mode skips black: 0 and the last pattern both wrap to 1.
            pat_d = ((pat_q == PAT_BLACK) || (pat_q >= LAST_PAT)) ? 4'd1 : pat_q + 4'd1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         pat_d = pat_q;
         cnt_d = cnt_q;
      end
   end

   // Pattern and frame counter registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pat_q <= PAT_BLACK;
         cnt_q <= 8'd0;
      end else begin
         pat_q <= pat_d;
         cnt_q <= cnt_d;
      end
   end

   assign o_active_pattern = pat_q;

   // ---------------------------------------------------------------- box position
   logic [POS_WIDTH-1:0] box_x_s, box_y_s;

   tpg_bounce_box #(
      .POS_WIDTH (POS_WIDTH),
      .H_EXTENT  (H_VISIBLE),
      .V_EXTENT  (V_VISIBLE),
      .SIZE      (BOX_SIZE),
      .STEP      (BOX_STEP)
   ) u_box (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_strobe (i_frame_strobe),
      .o_x      (box_x_s),
      .o_y      (box_y_s)
   );

   // ---------------------------------------------------------------- stage 1 terms
   int                   hp_s, vp_s, bx_s, by_s;
   logic [2:0]           bar_s;
   logic                 border_s;
   logic [COLOR_WIDTH-1:0] ramp_s;
   logic                 box_s;

   assign hp_s = int'(i_hpos);
   assign vp_s = int'(i_vpos);
   assign bx_s = int'(box_x_s);
   assign by_s = int'(box_y_s);

   // Per-pattern terms as compare chains (no dividers); positions past the
   // last bar fall back to bar 0, past the last ramp band to full scale.
   always_comb begin
      bar_s = 3'd0;
      for (int b = 1; b < 8; b++) begin
         if (hp_s >= b * BAR_W) bar_s = 3'(b);
         else                   bar_s = bar_s;
      end
      if (hp_s >= 8 * BAR_W) bar_s = 3'd0;
      else                   bar_s = bar_s;

      ramp_s = '0;
      for (int k = 1; k < NUM_BANDS; k++) begin
         if (hp_s >= k * BAND_W) ramp_s = COLOR_WIDTH'(k);
         else                    ramp_s = ramp_s;
      end
      if (hp_s >= NUM_BANDS * BAND_W) ramp_s = ONES;
      else                            ramp_s = ramp_s;

      border_s = (hp_s == 0) || (hp_s == H_VISIBLE - 1) ||
                 (vp_s == 0) || (vp_s == V_VISIBLE - 1);

      box_s = (hp_s >= bx_s) && (hp_s < bx_s + BOX_SIZE) &&
              (vp_s >= by_s) && (vp_s < by_s + BOX_SIZE);
   end

`ifdef TPG_CROSSHAIR_EN
   logic cross_s, cross1_q;
   assign cross_s = (hp_s == H_VISIBLE / 2) || (vp_s == V_VISIBLE / 2);

   // Crosshair flag travels with the other stage-1 terms.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) cross1_q <= 1'b0;
      else          cross1_q <= cross_s;
   end
`endif

   logic                   vis1_q, border1_q, box1_q;
   logic [3:0]             pat1_q;
   logic [2:0]             bar1_q;
   logic [COLOR_WIDTH-1:0] ramp1_q;

   // Stage 1 registers; the pattern is sampled here so a pixel keeps one pattern.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vis1_q    <= 1'b0;
         pat1_q    <= PAT_BLACK;
         bar1_q    <= 3'd0;
         border1_q <= 1'b0;
         ramp1_q   <= '0;
         box1_q    <= 1'b0;
      end else begin
         vis1_q    <= i_visible;
         pat1_q    <= pat_q;
         bar1_q    <= bar_color(bar_s);
         border1_q <= border_s;
         ramp1_q   <= ramp_s;
         box1_q    <= box_s;
      end
   end

   // ---------------------------------------------------------------- stage 2 mux
   logic [COLOR_WIDTH-1:0] red_d, grn_d, blu_d;
   logic [COLOR_WIDTH-1:0] red_q, grn_q, blu_q;

   // Colour mux; everything is black unless the delayed visible bit is set.
   always_comb begin
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
      if (vis1_q) begin
         case (pat1_q)
            PAT_RED:   red_d = ONES;
            PAT_GREEN: grn_d = ONES;
            PAT_BLUE:  blu_d = ONES;
            PAT_BARS: begin
               red_d = {COLOR_WIDTH{bar1_q[2]}};
               grn_d = {COLOR_WIDTH{bar1_q[1]}};
               blu_d = {COLOR_WIDTH{bar1_q[0]}};
            end
            PAT_BORDER: begin
               red_d = border1_q ? ONES : '0;
               grn_d = border1_q ? ONES : '0;
               blu_d = border1_q ? ONES : '0;
            end
            PAT_RAMP: begin
               red_d = ramp1_q;
               grn_d = ramp1_q;
               blu_d = ramp1_q;
            end
            PAT_BOX: begin
               red_d = box1_q ? ONES : '0;
               grn_d = box1_q ? ONES : '0;
               blu_d = ONES;
            end
            default: begin
               red_d = '0;
               grn_d = '0;
               blu_d = '0;
            end
         endcase
`ifdef TPG_CROSSHAIR_EN
         if (cross1_q && (pat1_q != PAT_BLACK)) begin
            red_d = ONES;
            grn_d = ONES;
            blu_d = ONES;
         end else begin
            red_d = red_d;
         end
`endif
      end else begin
         red_d = '0;
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         red_q <= '0;
         grn_q <= '0;
         blu_q <= '0;
      end else begin
         red_q <= red_d;
         grn_q <= grn_d;
         blu_q <= blu_d;
      end
   end

   assign o_red_video = red_q;
   assign o_grn_video = grn_q;
   assign o_blu_video = blu_q;

endmodule

// File: tb/tb_tpg_engine.sv
// -----------------------------------------------------------------------------
// tb_tpg_engine -- directed self-checking bench for tpg_engine
// (default parameters except AUTO_FRAMES = 3). Colours are compared as a
// 9-bit {red, green, blue} word.
// -----------------------------------------------------------------------------
module tb_tpg_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] pattern;
   logic       auto_en;
   logic [9:0] hpos, vpos;
   logic       visible;
   logic       strobe_in;
   logic [2:0] red, grn, blu;
   logic [3:0] active;
   logic [8:0] rgb;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [8:0] BLACK = 9'b000_000_000;
   localparam logic [8:0] WHITE = 9'b111_111_111;
   localparam logic [8:0] RED   = 9'b111_000_000;
   localparam logic [8:0] GREEN = 9'b000_111_000;
   localparam logic [8:0] BLUE  = 9'b000_000_111;

   assign rgb = {red, grn, blu};

   always #5 clk = ~clk;

   tpg_engine #(.AUTO_FRAMES(3)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_pattern        (pattern),
      .i_auto_en        (auto_en),
      .i_hpos           (hpos),
      .i_vpos           (vpos),
      .i_visible        (visible),
      .i_frame_strobe   (strobe_in),
      .o_red_video      (red),
      .o_grn_video      (grn),
      .o_blu_video      (blu),
      .o_active_pattern (active)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      strobe_in = 1'b1;
      tick();
      strobe_in = 1'b0;
   endtask

   task automatic set_px(input int h, input int v, input logic vis);
      hpos    = 10'(h);
      vpos    = 10'(v);
      visible = vis;
   endtask

   // Present a pixel and wait out the two-cycle latency.
   task automatic px(input int h, input int v, input logic vis);
      set_px(h, v, vis);
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_manual(input logic [3:0] p);
      pattern = p;
      strobe();
   endtask

   int exp_pat;
   int adv;

   initial begin
      rst_n = 1'b0; pattern = 4'd0; auto_en = 1'b0; strobe_in = 1'b0;
      set_px(0, 0, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      check("reset_rgb", 32'(rgb), 32'(BLACK));
      check("reset_pat", 32'(active), 32'd0);

      // Manual green, latency and blanking
      set_manual(4'd2);
      check("man_pat2", 32'(active), 32'd2);
      px(100, 100, 1'b0);
      set_px(100, 100, 1'b1);
      tick();
      check("latency_1cyc", 32'(rgb), 32'(BLACK));
      tick();
      check("green_2cyc", 32'(rgb), 32'(GREEN));
      px(100, 100, 1'b0);
      check("green_blank", 32'(rgb), 32'(BLACK));

      // Out-of-range request loads black
      set_manual(4'd12);
      check("pat12_to_0", 32'(active), 32'd0);
      px(100, 100, 1'b1);
      check("pat12_rgb", 32'(rgb), 32'(BLACK));

      set_manual(4'd1); px(10, 10, 1'b1);
      check("red", 32'(rgb), 32'(RED));
      set_manual(4'd3); px(10, 10, 1'b1);
      check("blue", 32'(rgb), 32'(BLUE));

      // Colour bars
      set_manual(4'd4);
      px(0,   5, 1'b1); check("bar0",   32'(rgb), 32'(WHITE));
      px(80,  5, 1'b1); check("bar1",   32'(rgb), 32'(9'b111_111_000));
      px(160, 5, 1'b1); check("bar2",   32'(rgb), 32'(9'b000_111_111));
      px(320, 5, 1'b1); check("bar4",   32'(rgb), 32'(9'b111_000_111));
      px(639, 5, 1'b1); check("bar7",   32'(rgb), 32'(BLACK));
      px(700, 5, 1'b1); check("bar_ov", 32'(rgb), 32'(WHITE));

      // Border
      set_manual(4'd5);
      px(0,   100, 1'b1); check("brd_l",  32'(rgb), 32'(WHITE));
      px(639, 200, 1'b1); check("brd_r",  32'(rgb), 32'(WHITE));
      px(320, 0,   1'b1); check("brd_t",  32'(rgb), 32'(WHITE));
      px(320, 479, 1'b1); check("brd_b",  32'(rgb), 32'(WHITE));
      px(1,   1,   1'b1); check("brd_in1", 32'(rgb), 32'(BLACK));
      px(638, 478, 1'b1); check("brd_in2", 32'(rgb), 32'(BLACK));

      // Grey ramp, bands of 80 pixels
      set_manual(4'd6);
      px(0,   50, 1'b1); check("ramp0",   32'(rgb), 32'(BLACK));
      px(79,  50, 1'b1); check("ramp79",  32'(rgb), 32'(BLACK));
      px(80,  50, 1'b1); check("ramp80",  32'(rgb), 32'(9'b001_001_001));
      px(400, 50, 1'b1); check("ramp400", 32'(rgb), 32'(9'b101_101_101));
      px(639, 50, 1'b1); check("ramp639", 32'(rgb), 32'(WHITE));

      // Auto cycle from pattern 0, AUTO_FRAMES = 3
      set_manual(4'd0);
      check("auto_start", 32'(active), 32'd0);
      auto_en = 1'b1;
      for (int n = 1; n <= 25; n++) begin
         strobe();
         adv = n / 3;
         exp_pat = (adv == 0) ? 0 : ((adv - 1) % 7) + 1;
         check($sformatf("auto_s%0d", n), 32'(active), 32'(exp_pat));
      end
      // Counter holds 1 here; dropping auto_en must clear it
      auto_en = 1'b0;
      tick();
      auto_en = 1'b1;
      strobe(); strobe();
      check("auto_clr_hold", 32'(active), 32'd1);
      strobe();
      check("auto_clr_adv", 32'(active), 32'd2);
      auto_en = 1'b0;

      // Mid-frame reset: blanks next edge and clears the auto counter
      set_manual(4'd1);
      px(10, 10, 1'b1);
      check("pre_rst_red", 32'(rgb), 32'(RED));
      do_reset();
      check("rst_rgb", 32'(rgb), 32'(BLACK));
      check("rst_pat", 32'(active), 32'd0);
      auto_en = 1'b1;
      strobe(); strobe();
      do_reset();
      strobe(); strobe();
      check("rst_cnt_hold", 32'(active), 32'd0);
      strobe();
      check("rst_cnt_adv", 32'(active), 32'd1);
      auto_en = 1'b0;

      // Bouncing box from reset: after strobe n (n <= 224) the corner is (2n, 2n)
      do_reset();
      set_manual(4'd7);
      check("box_pat", 32'(active), 32'd7);
      px(2,  2,  1'b1); check("box1_in",   32'(rgb), 32'(WHITE));
      px(1,  2,  1'b1); check("box1_outl", 32'(rgb), 32'(BLUE));
      px(33, 33, 1'b1); check("box1_br",   32'(rgb), 32'(WHITE));
      px(34, 34, 1'b1); check("box1_out",  32'(rgb), 32'(BLUE));
      repeat (223) strobe();
      px(448, 448, 1'b1); check("box224_in",  32'(rgb), 32'(WHITE));
      px(448, 447, 1'b1); check("box224_out", 32'(rgb), 32'(BLUE));
      px(479, 479, 1'b1); check("box224_br",  32'(rgb), 32'(WHITE));
      strobe();
      // y reflected: (450, 446)
      px(450, 446, 1'b1); check("box225_in",  32'(rgb), 32'(WHITE));
      px(450, 445, 1'b1); check("box225_out", 32'(rgb), 32'(BLUE));
      repeat (79) strobe();
      // x hits the right limit: (608, 288)
      px(608, 288, 1'b1); check("box304_in",  32'(rgb), 32'(WHITE));
      px(607, 288, 1'b1); check("box304_out", 32'(rgb), 32'(BLUE));
      px(639, 288, 1'b1); check("box304_r",   32'(rgb), 32'(WHITE));
      strobe();
      // x reflected: (606, 286)
      px(606, 286, 1'b1); check("box305_in",  32'(rgb), 32'(WHITE));
      px(637, 286, 1'b1); check("box305_r",   32'(rgb), 32'(WHITE));
      px(638, 286, 1'b1); check("box305_out", 32'(rgb), 32'(BLUE));
      px(606, 285, 1'b1); check("box305_top", 32'(rgb), 32'(BLUE));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
